// File: rtl/mem_writer.sv
// Byte-to-word packer that fills a small word memory.
// Bytes are packed little-endian and the memory is read back combinationally.
module mem_writer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          clr,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  output logic [AW:0]   wr_count,
  output logic          full,
  output logic          wr_done
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t        state_r, state_next_s;
  logic [1:0]    k_r;
  logic [23:0]   buf_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW:0]   wr_count_r;
  logic          wr_done_r;
  logic [31:0]   mem_r [DEPTH];

  logic          accept_s;
  logic          commit_s;
  logic          last_word_s;
  logic [31:0]   word_s;

  // Unfilled lanes of buf_r are kept at zero, so OR-ing in the new byte
  // yields the zero-padded word on an early commit.
  // Handshake, commit decision and word assembly.
  always_comb begin
    in_ready    = (state_r != ST_FULL) && !clr;
    accept_s    = in_valid && in_ready;
    commit_s    = accept_s && ((k_r == 2'd3) || in_last);
    last_word_s = (wr_count_r == (AW+1)'(DEPTH - 1));
    word_s      = {8'h00, buf_r} | ({24'h000000, in_data} << {k_r, 3'b000});
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_EMPTY, ST_FILL: begin
        if (clr) begin
          state_next_s = ST_EMPTY;
        end else if (commit_s) begin
          state_next_s = last_word_s ? ST_FULL : ST_EMPTY;
        end else if (accept_s) begin
          state_next_s = ST_FILL;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_FULL: begin
        if (clr) begin
          state_next_s = ST_EMPTY;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Packer, pointer, count and done pulse.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      k_r        <= 2'd0;
      buf_r      <= 24'h000000;
      wr_ptr_r   <= '0;
      wr_count_r <= '0;
      wr_done_r  <= 1'b0;
    end else if (clr) begin
      k_r        <= 2'd0;
      buf_r      <= 24'h000000;
      wr_ptr_r   <= '0;
      wr_count_r <= '0;
      wr_done_r  <= 1'b0;
    end else begin
      wr_done_r <= commit_s;
      if (commit_s) begin
        k_r        <= 2'd0;
        buf_r      <= 24'h000000;
        wr_ptr_r   <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        wr_count_r <= wr_count_r + {{AW{1'b0}}, 1'b1};
      end else if (accept_s) begin
        k_r   <= k_r + 2'd1;
        buf_r <= word_s[23:0];
      end
    end
  end

  // Word memory; clr deliberately leaves contents intact.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h00000000;
      end
    end else if (commit_s && !clr) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

  assign rd_data  = mem_r[rd_addr];
  assign wr_count = wr_count_r;
  assign full     = (state_r == ST_FULL);
  assign wr_done  = wr_done_r;

endmodule

// File: doc/mem_writer.md
MEM_WRITER -- requirements
Module: mem_writer

Interface
REQ-001 Parameter: DEPTH, 16, number of 32-bit words in the write-side memory.
REQ-002 Parameter: AW, 4, address width, equal to log2(DEPTH).
REQ-003 sys_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 sys_rst  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous clear of write pointer, packer and count.
REQ-006 in_data  input  8  byte to be written.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_last  input  1  the accepted byte closes the current word early.
REQ-009 in_ready  output  1  block accepts a byte this cycle.
REQ-010 rd_addr  input  AW  word address for the read port.
REQ-011 rd_data  output  32  mem[rd_addr], combinational.
REQ-012 wr_count  output  AW+1  number of words committed since reset or clr (0..DEPTH).
REQ-013 full  output  1  wr_count == DEPTH.
REQ-014 wr_done  output  1  one-cycle pulse in the cycle after each word commit.

Function
REQ-015 A byte is accepted on a rising edge where in_valid && in_ready.
REQ-016 State machine: EMPTY (no partial bytes), FILL (1-3 bytes held), FULL (wr_count == DEPTH).
REQ-017 Bytes pack little-endian: the k-th byte of a word (k = 0..3) goes to bits [8k+7:8k].
REQ-018 Commit rule: a byte accepted with k == 3 or in_last == 1 writes the word to mem[wr_ptr] on that same edge.
REQ-019 On commit, byte lanes not yet filled are written as 0x00.
REQ-020 On commit, wr_ptr and wr_count increment by 1 and the packer returns to k = 0.
REQ-021 Transitions: EMPTY->FILL on an accept without commit; FILL->EMPTY on commit; EMPTY/FILL->FULL on a commit that makes wr_count == DEPTH; FULL->EMPTY only on clr or reset.
REQ-022 in_ready = 1 in EMPTY and FILL, 0 in FULL and while clr == 1.
REQ-023 wr_ptr is AW bits wide; it wraps to 0 only together with the transition into FULL.
REQ-024 A write is never performed in FULL; bytes presented while in_ready == 0 are ignored.
REQ-025 rd_data reflects a commit from the cycle after the commit edge.
REQ-026 A read of an address not yet written returns 0.
REQ-027 clr has priority over a simultaneous byte accept: the byte is dropped, and pointer, count and packer go to 0.
REQ-028 clr leaves memory contents unchanged.
REQ-029 An in_last byte arriving with k == 3 produces a single commit, not two.
REQ-030 wr_done is registered and asserts exactly once per commit.

Reset
REQ-031 While sys_rst == 0, asynchronously: state = EMPTY, wr_ptr = 0, k = 0, wr_count = 0, full = 0, wr_done = 0, every memory word = 0.
REQ-032 in_ready = 1 in the first cycle after sys_rst deasserts.
REQ-033 Reset asserted mid-word discards the partial bytes; nothing is committed.

Verification
REQ-034 After reset, stream bytes 0x11, 0x22, 0x33, 0x44 back-to-back -> mem[0] = 0x44332211, wr_count = 1, wr_done high one cycle later.
REQ-035 Send 0xAA, then 0xBB with in_last = 1 -> mem[1] = 0x0000BBAA; the next byte starts a new word at k = 0.
REQ-036 Commit 16 full words -> full = 1, in_ready = 0; a further valid byte leaves mem and wr_count = 16 unchanged.
REQ-037 From FULL, pulse clr with in_valid = 1 -> byte dropped, wr_count = 0, old memory still readable; the next word overwrites mem[0].
REQ-038 Accept 2 bytes, then assert sys_rst low -> wr_count = 0 and mem[rd_addr] = 0 for all addresses; the next 4 bytes land in mem[0].
REQ-039 Randomly toggle in_valid with 0x01..0x40 -> rd_data sweep over addresses 0..15 matches the packed reference model.
